jt12_param_acc: RTL and testbench
=================================

Name: jt12_param_acc

Overview:
- Parametrised FM output accumulator for the YM2203/YM2612/YM2610 family.
- Sums carrier-operator results over one sample frame. Supports mono or stereo with per-operand pan, and saturates at the accumulator width.
- Latches the frame result with a sample strobe and flags lost frame sync.
- Sits between the operator pipeline and the mixer/interpolator.

Parameters:
- WIN, 14, operator result width, signed
- WACC, 18, accumulator width, signed, WACC > WIN
- WOUT, 16, output width, WOUT <= WACC; output is accumulator bits [WACC-1 : WACC-WOUT]
- STEREO, 1, 1 = separate L/R accumulators driven by pan; 0 = single accumulator, snd_r mirrors snd_l
- NSLOT, 24, operand slots per frame (12 for 3-channel YM2203 use, 24 for 6-channel)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- clk_en  in  1  operand-rate enable; all state advances only when high (except reset)
- op_result  in  WIN  signed operator output for the current slot
- s1_enters, s2_enters, s3_enters, s4_enters  in  1 each  operator-position flags for the current slot
- alg  in  3  algorithm of the current slot's channel
- pan  in  2  [1]=left enable, [0]=right enable for the current slot; ignored when STEREO=0
- zero  in  1  marks the first slot of a frame
- snd_l  out  WOUT  signed left (or mono) sample
- snd_r  out  WOUT  signed right sample
- sample  out  1  one-clk pulse: new snd_l/snd_r are valid
- sync_err  out  1  sticky: frame ran past NSLOT slots without zero

Behaviour:
- Reset (rst=1 at a clk edge, regardless of clk_en) clears the following to 0:
  - accumulators and snd_l/snd_r
  - sample and sync_err
  - slot counter
- Reset mid-frame discards the partial sums.
- sum_en (combinational):
  - alg 0-3: s4_enters
  - alg 4: s2_enters|s4_enters
  - alg 5,6: ~s1_enters
  - alg 7: 1
- Operand contribution: op_result sign-extended to WACC when sum_en=1, else 0.
- Per-side gating:
  - Left adds only if pan[1] (or STEREO=0).
  - Right adds only if pan[0] (STEREO=1 only).
- On a clk_en cycle with zero=1 (frame boundary):
  - snd_l <= accL[WACC-1 -: WOUT] and snd_r likewise (snd_r <= snd_l source when STEREO=0). These are the sums of the previous frame, excluding the current operand.
  - Accumulators reload with the current gated contribution, not 0.
  - Slot counter <= 1.
  - sample pulses high on the next clk cycle for exactly one clk, independent of clk_en.
- On a clk_en cycle with zero=0:
  - acc <= sat(acc + contribution).
  - Slot counter increments.
- Saturation:
  - Sum computed at WACC+1 bits.
  - Clamp to +(2^(WACC-1)-1) or -(2^(WACC-1)).
  - A saturated accumulator can still move back into range on later operands.
- Sync check: a zero=0 clk_en cycle that finds the slot counter at NSLOT sets sync_err. The counter then holds at NSLOT and accumulation continues. sync_err clears only on rst.
- First zero after reset: outputs 0 and still pulses sample.
- clk_en=0: no state change except that a pending sample pulse still completes.
- Latency: op_result to its inclusion in snd is at most NSLOT clk_en cycles. Boundary to sample pulse is 1 clk.

Test Plan:
- WIN=14/WACC=18/WOUT=16, STEREO=1, alg=7, pan=2'b11, 24 slots of op_result=100, then zero -> snd_l=snd_r=600 (2400>>2), sample high 1 clk.
- alg=0, pulse s4_enters only on 6 slots with +1000, the other 18 slots +5000 -> snd_l=1500; alg=4 with s2 and s4 each on 6 slots of +1000, the rest +5000 -> snd_l=3000.
- Pan split: 12 slots pan=2'b10 with +4000, 12 slots pan=2'b01 with -4000, alg=7 -> snd_l=12000, snd_r=-12000; repeat with STEREO=0 -> snd_l=snd_r=0.
- Saturation: 24 slots of +8191, alg=7 -> acc clamps at 131071, snd=32767; 24 slots of -8192 -> snd=-32768; clamp then 1 slot of -8192 -> acc=122879.
- Sync loss: NSLOT=24, 30 clk_en cycles with zero=0 -> sync_err rises on the 24th post-boundary cycle and stays high after later zeros until rst.
- rst asserted mid-frame with clk_en=0 -> next edge clears acc/snd/sync_err; next frame sums from 0; clk_en low during the frame -> no accumulation.

Source files
------------

// File: rtl/jt12_param_acc.sv
// jt12_param_acc: FM carrier-operator accumulator for the YM2203/2612/2610
// family. Sums one sample frame of operator results, latches the result.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   clk_en     operand-rate enable; all state moves only when high
//   op_result  signed operator output for the current slot (WIN bits)
//   s1..s4_enters  operator-position flags for the current slot
//   alg        algorithm of the current slot's channel
//   pan        [1] left enable, [0] right enable (STEREO=1 only)
//   zero       first slot of a frame
//   snd_l      signed left/mono sample (WOUT bits)
//   snd_r      signed right sample, mirrors snd_l when STEREO=0
//   sample     one-clk pulse after a frame boundary: snd_* updated
//   sync_err   sticky: frame ran past NSLOT slots without zero

module jt12_param_acc #(
  parameter int WIN    = 14,
  parameter int WACC   = 18,
  parameter int WOUT   = 16,
  parameter int STEREO = 1,
  parameter int NSLOT  = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clk_en,
  input  logic signed [WIN-1:0]  op_result,
  input  logic                   s1_enters,
  input  logic                   s2_enters,
  input  logic                   s3_enters,
  input  logic                   s4_enters,
  input  logic [2:0]             alg,
  input  logic [1:0]             pan,
  input  logic                   zero,
  output logic signed [WOUT-1:0] snd_l,
  output logic signed [WOUT-1:0] snd_r,
  output logic                   sample,
  output logic                   sync_err
);

  localparam int CW = $clog2(NSLOT + 1);

  localparam logic [CW-1:0] SLOT_MAX = CW'(NSLOT);
  localparam logic [CW-1:0] SLOT_ONE = CW'(1);

  localparam logic signed [WACC-1:0] ACC_MAX =
    {1'b0, {(WACC-1){1'b1}}};
  localparam logic signed [WACC-1:0] ACC_MIN =
    {1'b1, {(WACC-1){1'b0}}};

  logic signed [WACC-1:0] acc_l;
  logic signed [WACC-1:0] acc_r;
  logic        [CW-1:0]   cnt;

  logic                   sum_en;
  logic                   gate_l;
  logic                   gate_r;
  logic signed [WACC-1:0] op_ext;
  logic signed [WACC-1:0] add_l;
  logic signed [WACC-1:0] add_r;
  logic signed [WACC-1:0] nxt_l;
  logic signed [WACC-1:0] nxt_r;

  // s3 never decides carrier status in any algorithm
  logic unused_s3;
  assign unused_s3 = s3_enters;

  // Add with one guard bit, clamp on overflow.
  function automatic logic signed [WACC-1:0] sat_add(
    input logic signed [WACC-1:0] a,
    input logic signed [WACC-1:0] b
  );
    logic [WACC:0] s;
    s = {a[WACC-1], a} + {b[WACC-1], b};
    if (s[WACC] != s[WACC-1])
      sat_add = s[WACC] ? ACC_MIN : ACC_MAX;
    else
      sat_add = s[WACC-1:0];
  endfunction

  // Carrier decode: which operator positions reach the output
  always_comb begin
    sum_en = 1'b0;
    unique case (alg)
      3'd0, 3'd1,
      3'd2, 3'd3: sum_en = s4_enters;
      3'd4:       sum_en = s2_enters | s4_enters;
      3'd5, 3'd6: sum_en = ~s1_enters;
      default:    sum_en = 1'b1;
    endcase
  end

  always_comb begin
    op_ext = {{(WACC-WIN){op_result[WIN-1]}}, op_result};
    gate_l = sum_en & ((STEREO == 0) | pan[1]);
    gate_r = sum_en & (STEREO != 0) & pan[0];
    add_l  = gate_l ? op_ext : '0;
    add_r  = gate_r ? op_ext : '0;
  end

  // A boundary slot reloads with its own operand, it does not clear
  always_comb begin
    nxt_l = add_l;
    nxt_r = add_r;
    if (!zero) begin
      nxt_l = sat_add(acc_l, add_l);
      nxt_r = sat_add(acc_r, add_r);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_l    <= '0;
      acc_r    <= '0;
      snd_l    <= '0;
      snd_r    <= '0;
      sample   <= 1'b0;
      sync_err <= 1'b0;
      cnt      <= '0;
    end else begin
      // strobe is a plain clk pulse, not held by clk_en
      sample <= clk_en & zero;
      if (clk_en) begin
        acc_l <= nxt_l;
        acc_r <= nxt_r;
        if (zero) begin
          snd_l <= acc_l[WACC-1 -: WOUT];
          snd_r <= (STEREO != 0) ?
                   acc_r[WACC-1 -: WOUT] :
                   acc_l[WACC-1 -: WOUT];
          cnt   <= SLOT_ONE;
        end else if (cnt == SLOT_MAX) begin
          sync_err <= 1'b1;
        end else begin
          cnt <= cnt + SLOT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_jt12_param_acc.sv
// tb_jt12_param_acc: stereo and mono instances driven in parallel,
// checked every cycle against an integer frame-sum model.

module tb_jt12_param_acc;

  localparam int WIN   = 14;
  localparam int WACC  = 18;
  localparam int WOUT  = 16;
  localparam int NSLOT = 24;
  localparam int SH    = WACC - WOUT;
  localparam int AMAX  = (1 << (WACC-1)) - 1;
  localparam int AMIN  = -(1 << (WACC-1));

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_en = 1'b0;
  logic signed [WIN-1:0] op_result = '0;
  logic s1 = 0, s2 = 0, s3 = 0, s4 = 0;
  logic [2:0] alg = '0;
  logic [1:0] pan = '0;
  logic zero = 1'b0;

  logic signed [WOUT-1:0] st_l, st_r, mo_l, mo_r;
  logic st_s, st_e, mo_s, mo_e;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  jt12_param_acc #(
    .WIN(WIN), .WACC(WACC), .WOUT(WOUT),
    .STEREO(1), .NSLOT(NSLOT)
  ) u_st (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .op_result(op_result),
    .s1_enters(s1), .s2_enters(s2),
    .s3_enters(s3), .s4_enters(s4),
    .alg(alg), .pan(pan), .zero(zero),
    .snd_l(st_l), .snd_r(st_r),
    .sample(st_s), .sync_err(st_e)
  );

  jt12_param_acc #(
    .WIN(WIN), .WACC(WACC), .WOUT(WOUT),
    .STEREO(0), .NSLOT(NSLOT)
  ) u_mo (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .op_result(op_result),
    .s1_enters(s1), .s2_enters(s2),
    .s3_enters(s3), .s4_enters(s4),
    .alg(alg), .pan(pan), .zero(zero),
    .snd_l(mo_l), .snd_r(mo_r),
    .sample(mo_s), .sync_err(mo_e)
  );

  task automatic chk(input string nm,
                     input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d @%0t",
               nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int ml, mr, mm;
  int esl, esr, esm;
  bit esmp, eerr;
  int slots;

  function automatic bit carrier(input logic [2:0] a,
                                 input logic [3:0] f);
    // f = {s1, s2, s3, s4}
    case (a)
      3'd0, 3'd1, 3'd2, 3'd3: return f[0];
      3'd4:                   return f[2] | f[0];
      3'd5, 3'd6:             return !f[3];
      default:                return 1'b1;
    endcase
  endfunction

  function automatic int clamp(input int v);
    if (v > AMAX) return AMAX;
    if (v < AMIN) return AMIN;
    return v;
  endfunction

  always @(posedge clk) begin
    int c, cl, cr;
    if (rst) begin
      ml = 0; mr = 0; mm = 0;
      esl = 0; esr = 0; esm = 0;
      esmp = 0; eerr = 0; slots = 0;
    end else begin
      esmp = clk_en && zero;
      if (clk_en) begin
        c  = carrier(alg, {s1, s2, s3, s4}) ? int'(op_result) : 0;
        cl = pan[1] ? c : 0;
        cr = pan[0] ? c : 0;
        if (zero) begin
          esl = ml >>> SH;
          esr = mr >>> SH;
          esm = mm >>> SH;
          ml = cl; mr = cr; mm = c;
          slots = 1;
        end else begin
          ml = clamp(ml + cl);
          mr = clamp(mr + cr);
          mm = clamp(mm + c);
          if (slots >= NSLOT) eerr = 1;
          else slots++;
        end
      end
    end
    #1;
    chk("st_l", st_l, esl);
    chk("st_r", st_r, esr);
    chk("st_smp", st_s, esmp);
    chk("st_err", st_e, eerr);
    chk("mo_l", mo_l, esm);
    chk("mo_r", mo_r, esm);
    chk("mo_smp", mo_s, esmp);
    chk("mo_err", mo_e, eerr);
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit z, input bit en,
                       input logic [2:0] a,
                       input logic [3:0] f,
                       input logic [1:0] p,
                       input int v);
    @(negedge clk);
    zero = z; clk_en = en; alg = a; pan = p;
    {s1, s2, s3, s4} = f;
    op_result = v[WIN-1:0];
  endtask

  task automatic frame_const(input logic [2:0] a,
                             input logic [1:0] p,
                             input int v);
    for (int i = 0; i < NSLOT; i++)
      drive(i == 0, 1'b1, a, 4'b0000, p, v);
  endtask

  // zero slot carrying nothing; checks the latched frame
  task automatic boundary(input string nm, input int el,
                          input int er, input int em);
    drive(1'b1, 1'b1, 3'd0, 4'b0000, 2'b11, 0);
    @(posedge clk); #2;
    chk({nm, "_smp"}, st_s, 1);
    chk({nm, "_l"}, st_l, el);
    chk({nm, "_r"}, st_r, er);
    chk({nm, "_ml"}, mo_l, em);
    chk({nm, "_mr"}, mo_r, em);
  endtask

  initial begin
    int k;
    rst = 1'b1;
    repeat (2) drive(1'b0, 1'b1, 3'd7, 4'b0000, 2'b11, 100);
    @(posedge clk); #2;
    chk("rst_l", st_l, 0);
    chk("rst_smp", st_s, 0);
    chk("rst_err", st_e, 0);
    rst = 1'b0;

    boundary("first", 0, 0, 0);

    frame_const(3'd7, 2'b11, 100);
    boundary("flat", 600, 600, 600);

    for (int i = 0; i < NSLOT; i++)
      if (i < 6) drive(i == 0, 1, 3'd0, 4'b0001, 2'b11, 1000);
      else       drive(0, 1, 3'd0, 4'b0000, 2'b11, 5000);
    boundary("alg0", 1500, 1500, 1500);

    for (int i = 0; i < NSLOT; i++)
      if (i < 6)       drive(i == 0, 1, 3'd4, 4'b0100, 2'b11, 1000);
      else if (i < 12) drive(0, 1, 3'd4, 4'b0001, 2'b11, 1000);
      else             drive(0, 1, 3'd4, 4'b0000, 2'b11, 5000);
    boundary("alg4", 3000, 3000, 3000);

    for (int i = 0; i < NSLOT; i++)
      if (i < 12) drive(i == 0, 1, 3'd7, 4'b0000, 2'b10, 4000);
      else        drive(0, 1, 3'd7, 4'b0000, 2'b01, -4000);
    boundary("pan", 12000, -12000, 0);

    frame_const(3'd7, 2'b11, 8191);
    boundary("satp", 32767, 32767, 32767);
    frame_const(3'd7, 2'b11, -8192);
    boundary("satn", -32768, -32768, -32768);
    for (int i = 0; i < NSLOT; i++)
      drive(i == 0, 1, 3'd7, 4'b0000, 2'b11,
            (i < NSLOT-1) ? 8191 : -8192);
    boundary("unsat", 30719, 30719, 30719);

    for (int i = 1; i <= 30; i++) begin
      drive(1'b0, 1'b1, 3'd7, 4'b0000, 2'b11, 10);
      @(posedge clk); #2;
      chk($sformatf("sync%0d", i), st_e, (i >= 24) ? 1 : 0);
    end
    boundary("sync", 75, 75, 75);
    chk("sync_hold", st_e, 1);
    chk("sync_hold_m", mo_e, 1);

    for (int i = 0; i < 5; i++)
      drive(1'b0, 1'b1, 3'd7, 4'b0000, 2'b11, 500);
    rst = 1'b1;
    drive(1'b0, 1'b0, 3'd7, 4'b0000, 2'b11, 500);
    @(posedge clk); #2;
    chk("mid_rst_l", st_l, 0);
    chk("mid_rst_err", st_e, 0);
    rst = 1'b0;
    for (int i = 0; i < NSLOT; i++) begin
      drive(i == 0, 1, 3'd7, 4'b0000, 2'b11, 100);
      drive(i == 5, 0, 3'd7, 4'b0000, 2'b11, 7000);
    end
    boundary("gated", 600, 600, 600);
    chk("gated_err", st_e, 0);

    k = 0;
    for (int n = 0; n < 2000; n++) begin
      bit en, z;
      en = ($urandom % 5) != 0;
      z  = (k == 0);
      if ($urandom % 60 == 0) z = !z;
      rst = ($urandom % 400 == 0);
      drive(z, en, 3'($urandom), 4'($urandom), 2'($urandom),
            int'($urandom_range(0, 16383)) - 8192);
      if (en) k = z ? 1 : ((k + 1) % NSLOT);
    end
    rst = 1'b0;
    drive(1'b0, 1'b0, 3'd0, 4'b0000, 2'b00, 0);
    @(posedge clk); #3;

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
